// File: rtl/game_state_ctrl.sv
// Game state controller: run/pause/over FSM, per-frame sprite collision commit, lives/score.
// Optional GAME_BONUS_LIFE_EN: a committed bonus pickup adds one life.
module game_state_ctrl #(
  parameter int N_ENEMY       = 4,
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 3,
  parameter int SCORE_W       = 16,
  parameter int INVULN_FRAMES = 60,
  parameter int INV_W         = 8
) (
  input  logic               clk_vga,
  input  logic               rst_n,
  input  logic               frame_start_i,
  input  logic               disp_i,
  input  logic               me_alpha_i,
  input  logic               bullet_alpha_i,
  input  logic               bonus_alpha_i,
  input  logic [N_ENEMY-1:0] enemy_alpha_i,
  input  logic               gamestart_i,
  input  logic               pause_i,
  output logic [2:0]         game_status_o,
  output logic [N_ENEMY-1:0] crash_me_enemy_o,
  output logic [N_ENEMY-1:0] crash_enemy_bullet_o,
  output logic               crash_me_bonus_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic [SCORE_W-1:0] score_o
);

  typedef enum logic [2:0] {
    ST_PAUSE  = 3'b000,
    ST_RUN    = 3'b001,
    ST_PRERUN = 3'b010,
    ST_OVER   = 3'b011
  } state_t;

  localparam int PC_W = $clog2(N_ENEMY + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [LIVES_W-1:0] LIVES_MAX = '1;
  localparam logic [LIVES_W-1:0] LIVES_LD  = LIVES_W'(LIVES_INIT);
  localparam logic [INV_W-1:0]   INV_LD    = INV_W'(INVULN_FRAMES);

  state_t             r_state;
  logic [N_ENEMY-1:0] r_me_en;
  logic [N_ENEMY-1:0] r_en_bu;
  logic               r_me_bo;
  logic [N_ENEMY-1:0] r_crash_me_en;
  logic [N_ENEMY-1:0] r_crash_en_bu;
  logic               r_crash_me_bo;
  logic [LIVES_W-1:0] r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [INV_W-1:0]   r_inv;

  logic               w_run;
  logic               w_sample;
  logic [N_ENEMY-1:0] w_pix_me_en;
  logic [N_ENEMY-1:0] w_pix_en_bu;
  logic               w_pix_me_bo;
  logic               w_loss;
  logic               w_gain;
  logic               w_over;
  logic [PC_W-1:0]    w_pc;
  logic [SCORE_W:0]   w_score_sum;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [LIVES_W-1:0] w_lives_nxt;
  logic [INV_W-1:0]   w_inv_nxt;

  function automatic logic [PC_W-1:0] f_popcount(
    input logic [N_ENEMY-1:0] v
  );
    logic [PC_W-1:0] c;
    c = '0;
    for (int k = 0; k < N_ENEMY; k++)
      c = c + PC_W'(v[k]);
    return c;
  endfunction

  assign w_run       = (r_state == ST_RUN);
  assign w_sample    = w_run & disp_i;
  assign w_pix_me_en = {N_ENEMY{me_alpha_i}} & enemy_alpha_i;
  assign w_pix_en_bu = enemy_alpha_i & {N_ENEMY{bullet_alpha_i}};
  assign w_pix_me_bo = me_alpha_i & bonus_alpha_i;

  assign w_loss = (|r_me_en) & (r_inv == '0);
`ifdef GAME_BONUS_LIFE_EN
  assign w_gain = r_me_bo;
`else
  assign w_gain = 1'b0;
`endif

  assign w_pc        = f_popcount(r_en_bu);
  assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_pc);
  assign w_score_nxt = w_score_sum[SCORE_W] ? SCORE_MAX
                                            : w_score_sum[SCORE_W-1:0];

  // a hit and a bonus on the same commit cancel; the hit still arms invulnerability
  always_comb begin
    w_lives_nxt = r_lives;
    w_over      = 1'b0;
    if (w_loss && !w_gain) begin
      if (r_lives != '0)
        w_lives_nxt = r_lives - LIVES_W'(1);
      w_over = (r_lives <= LIVES_W'(1));
    end else if (w_gain && !w_loss && r_lives != LIVES_MAX) begin
      w_lives_nxt = r_lives + LIVES_W'(1);
    end
  end

  always_comb begin
    w_inv_nxt = r_inv;
    if (w_loss)
      w_inv_nxt = INV_LD;
    else if (r_inv != '0)
      w_inv_nxt = r_inv - INV_W'(1);
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PRERUN;
      r_lives <= '0;
      r_score <= '0;
      r_inv   <= '0;
    end else begin
      unique case (r_state)
        ST_PRERUN: begin
          if (gamestart_i) begin
            r_state <= ST_RUN;
            r_lives <= LIVES_LD;
            r_score <= '0;
            r_inv   <= '0;
          end
        end
        ST_RUN: begin
          if (frame_start_i) begin
            r_lives <= w_lives_nxt;
            r_score <= w_score_nxt;
            r_inv   <= w_inv_nxt;
          end
          if (frame_start_i && w_over)
            r_state <= ST_OVER;
          else if (pause_i)
            r_state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (pause_i)
            r_state <= ST_RUN;
        end
        ST_OVER: begin
          if (gamestart_i)
            r_state <= ST_PRERUN;
        end
        default: r_state <= ST_PRERUN;
      endcase
    end
  end

  // the pixel on the frame_start cycle seeds the new frame's flags
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_me_en       <= '0;
      r_en_bu       <= '0;
      r_me_bo       <= 1'b0;
      r_crash_me_en <= '0;
      r_crash_en_bu <= '0;
      r_crash_me_bo <= 1'b0;
    end else if (frame_start_i) begin
      r_crash_me_en <= w_run ? r_me_en : '0;
      r_crash_en_bu <= w_run ? r_en_bu : '0;
      r_crash_me_bo <= w_run & r_me_bo;
      r_me_en       <= w_sample ? w_pix_me_en : '0;
      r_en_bu       <= w_sample ? w_pix_en_bu : '0;
      r_me_bo       <= w_sample & w_pix_me_bo;
    end else begin
      r_crash_me_en <= '0;
      r_crash_en_bu <= '0;
      r_crash_me_bo <= 1'b0;
      if (w_sample) begin
        r_me_en <= r_me_en | w_pix_me_en;
        r_en_bu <= r_en_bu | w_pix_en_bu;
        r_me_bo <= r_me_bo | w_pix_me_bo;
      end
    end
  end

  assign game_status_o        = r_state;
  assign crash_me_enemy_o     = r_crash_me_en;
  assign crash_enemy_bullet_o = r_crash_en_bu;
  assign crash_me_bonus_o     = r_crash_me_bo;
  assign lives_o              = r_lives;
  assign score_o              = r_score;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a scoreboard queue.
// Build with GAME_BONUS_LIFE_EN to exercise the bonus-life path.
module tb_game_state_ctrl;

  localparam logic [2:0] S_PAUSE = 3'b000;
  localparam logic [2:0] S_RUN   = 3'b001;
  localparam logic [2:0] S_PRE   = 3'b010;
  localparam logic [2:0] S_OVER  = 3'b011;

`ifdef GAME_BONUS_LIFE_EN
  localparam logic [2:0] BONUS_LV = 3'd4;
`else
  localparam logic [2:0] BONUS_LV = 3'd3;
`endif

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic        frame_start_i;
  logic        disp_i;
  logic        me_alpha_i;
  logic        bullet_alpha_i;
  logic        bonus_alpha_i;
  logic [3:0]  enemy_alpha_i;
  logic        gamestart_i;
  logic        pause_i;
  logic [2:0]  game_status_o;
  logic [3:0]  crash_me_enemy_o;
  logic [3:0]  crash_enemy_bullet_o;
  logic        crash_me_bonus_o;
  logic [2:0]  lives_o;
  logic [15:0] score_o;

  game_state_ctrl dut (
    .clk_vga              (clk_vga),
    .rst_n                (rst_n),
    .frame_start_i        (frame_start_i),
    .disp_i               (disp_i),
    .me_alpha_i           (me_alpha_i),
    .bullet_alpha_i       (bullet_alpha_i),
    .bonus_alpha_i        (bonus_alpha_i),
    .enemy_alpha_i        (enemy_alpha_i),
    .gamestart_i          (gamestart_i),
    .pause_i              (pause_i),
    .game_status_o        (game_status_o),
    .crash_me_enemy_o     (crash_me_enemy_o),
    .crash_enemy_bullet_o (crash_enemy_bullet_o),
    .crash_me_bonus_o     (crash_me_bonus_o),
    .lives_o              (lives_o),
    .score_o              (score_o)
  );

  always #5 clk_vga = ~clk_vga;

  string       q_tag[$];
  logic [31:0] q_val[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic push(input string tag, input logic [31:0] v);
    q_tag.push_back(tag);
    q_val.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_vec++;
    if (q_val.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h, required a queued entry", obs);
      return;
    end
    t = q_tag.pop_front();
    e = q_val.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic idle();
    me_alpha_i     = 1'b0;
    bullet_alpha_i = 1'b0;
    bonus_alpha_i  = 1'b0;
    enemy_alpha_i  = '0;
    disp_i         = 1'b0;
  endtask

  task automatic pix(input logic me, input logic bu, input logic bo,
                     input logic [3:0] en, input logic dsp, input int n);
    me_alpha_i     = me;
    bullet_alpha_i = bu;
    bonus_alpha_i  = bo;
    enemy_alpha_i  = en;
    disp_i         = dsp;
    repeat (n) step();
    idle();
  endtask

  task automatic push_st(input logic [2:0] st, input logic [2:0] lv,
                         input logic [15:0] sc);
    push("status", 32'(st));
    push("lives", 32'(lv));
    push("score", 32'(sc));
  endtask

  task automatic pop_st();
    pop_chk(32'(game_status_o));
    pop_chk(32'(lives_o));
    pop_chk(32'(score_o));
  endtask

  task automatic push_cr(input string sfx, input logic [3:0] me,
                         input logic [3:0] eb, input logic bo);
    push({"crash_me_enemy", sfx}, 32'(me));
    push({"crash_enemy_bullet", sfx}, 32'(eb));
    push({"crash_me_bonus", sfx}, 32'(bo));
  endtask

  task automatic pop_cr();
    pop_chk(32'(crash_me_enemy_o));
    pop_chk(32'(crash_enemy_bullet_o));
    pop_chk(32'(crash_me_bonus_o));
  endtask

  task automatic commit(input logic pz, input logic [2:0] st,
                        input logic [2:0] lv, input logic [15:0] sc,
                        input logic [3:0] me, input logic [3:0] eb,
                        input logic bo);
    push_st(st, lv, sc);
    push_cr("", me, eb, bo);
    frame_start_i = 1'b1;
    pause_i       = pz;
    step();
    frame_start_i = 1'b0;
    pause_i       = 1'b0;
    pop_st();
    pop_cr();
    push_cr("_1cyc", 4'b0, 4'b0, 1'b0);
    step();
    pop_cr();
  endtask

  task automatic pulse_start(input logic [2:0] st, input logic [2:0] lv,
                             input logic [15:0] sc);
    push_st(st, lv, sc);
    gamestart_i = 1'b1;
    step();
    gamestart_i = 1'b0;
    pop_st();
  endtask

  task automatic pulse_pause(input logic [2:0] st, input logic [2:0] lv,
                             input logic [15:0] sc);
    push_st(st, lv, sc);
    pause_i = 1'b1;
    step();
    pause_i = 1'b0;
    pop_st();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    frame_start_i = 1'b0;
    gamestart_i   = 1'b0;
    pause_i       = 1'b0;
    idle();

    #2 rst_n = 1'b0;
    #1;
    push_st(S_PRE, 3'd0, 16'd0);
    push_cr("_rst", 4'b0, 4'b0, 1'b0);
    pop_st();
    pop_cr();
    step();
    step();
    rst_n = 1'b1;
    step();

    // overlaps outside RUN never set flags
    pix(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 3);
    commit(1'b0, S_PRE, 3'd0, 16'd0, 4'b0, 4'b0, 1'b0);

    pulse_start(S_RUN, 3'd3, 16'd0);

    // two enemy/bullet channels -> score +2; disp low ignored
    pix(1'b0, 1'b1, 1'b0, 4'b0100, 1'b1, 5);
    pix(1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1);
    pix(1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 2);
    commit(1'b0, S_RUN, 3'd3, 16'd2, 4'b0, 4'b0101, 1'b0);

    // overlap coincident with frame_start belongs to the next frame
    bullet_alpha_i = 1'b1;
    enemy_alpha_i  = 4'b0010;
    disp_i         = 1'b1;
    commit(1'b0, S_RUN, 3'd3, 16'd2, 4'b0, 4'b0, 1'b0);
    idle();
    commit(1'b0, S_RUN, 3'd3, 16'd3, 4'b0, 4'b0010, 1'b0);

    // multi-channel hit: one life, then 60 invulnerable frames
    pix(1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 2);
    commit(1'b0, S_RUN, 3'd2, 16'd3, 4'b1010, 4'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      pix(1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 2);
      commit(1'b0, S_RUN, 3'd2, 16'd3, 4'b1010, 4'b0, 1'b0);
    end
    pix(1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 2);
    commit(1'b0, S_RUN, 3'd1, 16'd3, 4'b1010, 4'b0, 1'b0);

    // pause: nothing reported, everything held
    pulse_pause(S_PAUSE, 3'd1, 16'd3);
    pix(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 3);
    commit(1'b0, S_PAUSE, 3'd1, 16'd3, 4'b0, 4'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 2);
    pulse_pause(S_RUN, 3'd1, 16'd3);
    commit(1'b0, S_RUN, 3'd1, 16'd3, 4'b0, 4'b0, 1'b0);

    // counter: 60 -> held in pause -> 59; 58 more frames leave 1
    for (int i = 0; i < 58; i++)
      commit(1'b0, S_RUN, 3'd1, 16'd3, 4'b0, 4'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1);
    commit(1'b0, S_RUN, 3'd1, 16'd3, 4'b0001, 4'b0, 1'b0);

    // last life lost; same-edge pause ignored
    pix(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1);
    commit(1'b1, S_OVER, 3'd0, 16'd3, 4'b0001, 4'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 2);
    commit(1'b0, S_OVER, 3'd0, 16'd3, 4'b0, 4'b0, 1'b0);
    pulse_pause(S_OVER, 3'd0, 16'd3);
    pulse_start(S_PRE, 3'd0, 16'd3);
    pulse_start(S_RUN, 3'd3, 16'd0);

    // bonus pickup
    pix(1'b1, 1'b0, 1'b1, 4'b0, 1'b1, 2);
    commit(1'b0, S_RUN, BONUS_LV, 16'd0, 4'b0, 4'b0, 1'b1);

`ifdef GAME_BONUS_LIFE_EN
    for (int i = 5; i <= 7; i++) begin
      pix(1'b1, 1'b0, 1'b1, 4'b0, 1'b1, 1);
      commit(1'b0, S_RUN, 3'(i), 16'd0, 4'b0, 4'b0, 1'b1);
    end
    pix(1'b1, 1'b0, 1'b1, 4'b0, 1'b1, 1);
    commit(1'b0, S_RUN, 3'd7, 16'd0, 4'b0, 4'b0, 1'b1);
    pix(1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 1);
    commit(1'b0, S_RUN, 3'd7, 16'd0, 4'b0100, 4'b0, 1'b1);
    pix(1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1);
    commit(1'b0, S_RUN, 3'd7, 16'd0, 4'b0100, 4'b0, 1'b0);
`endif

    // reset mid-frame discards flags
    pix(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 3);
    rst_n = 1'b0;
    #1;
    push_st(S_PRE, 3'd0, 16'd0);
    push_cr("_midrst", 4'b0, 4'b0, 1'b0);
    pop_st();
    pop_cr();
    step();
    rst_n = 1'b1;
    step();
    pulse_start(S_RUN, 3'd3, 16'd0);
    commit(1'b0, S_RUN, 3'd3, 16'd0, 4'b0, 4'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
